bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 116 +++++++++++
 tb/tb_bus_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave round-robin bus arbiter.
//
// Ports:
//   i_clk, i_reset         clock and synchronous active-high reset
//   i_mX_cs/we/addr/dat    master X request, write enable, address, write data
//   o_mX_dat               master X read data (8'hff on timeout)
//   o_mX_ack, o_mX_err     master X completion pulse and timeout flag
//   o_cs/we/addr/dat       slave request muxed from the current owner
//   i_dat, i_ack           slave read data and completion
//   o_grant                one-hot current owner (01 = m0, 10 = m1), 00 when idle
//
// TIMEOUT is the number of BUSY cycles without i_ack before the owner is
// completed with an error (legal range 1..255).
module bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_cs,
  input  logic        i_m0_we,
  input  logic [15:0] i_m0_addr,
  input  logic [7:0]  i_m0_dat,
  output logic [7:0]  o_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic        i_m1_cs,
  input  logic        i_m1_we,
  input  logic [15:0] i_m1_addr,
  input  logic [7:0]  i_m1_dat,
  output logic [7:0]  o_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic        o_cs,
  output logic        o_we,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dat,
  input  logic [7:0]  i_dat,
  input  logic        i_ack,
  output logic [1:0]  o_grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state;
  logic        r_owner;   // 0 = m0, 1 = m1
  logic        r_last;    // last master that finished or aborted
  logic [7:0]  r_cnt;
  logic [1:0]  r_grant;

  logic        owner_cs;
  logic        active;
  logic        done;
  logic        tmo;
  logic        abort;
  logic        next_owner;

  always_comb begin
    owner_cs   = r_owner ? i_m1_cs : i_m0_cs;
    // Reset masks the slave/master strobes even while the state is still BUSY.
    active     = (r_state == BUSY) && !i_reset;
    done       = active && i_ack;
    tmo        = active && !i_ack && owner_cs && (r_cnt == TIMEOUT - 8'd1);
    abort      = active && !i_ack && !owner_cs;
    // On a tie the master not served last wins; otherwise whoever asks.
    next_owner = (i_m0_cs && i_m1_cs) ? ~r_last : i_m1_cs;

    o_cs       = active && owner_cs;
    o_we       = active && (r_owner ? i_m1_we : i_m0_we);
    o_addr     = active ? (r_owner ? i_m1_addr : i_m0_addr) : '0;
    o_dat      = active ? (r_owner ? i_m1_dat : i_m0_dat) : '0;

    o_m0_ack   = (done || tmo) && !r_owner;
    o_m1_ack   = (done || tmo) && r_owner;
    o_m0_err   = tmo && !r_owner;
    o_m1_err   = tmo && r_owner;
    o_m0_dat   = (tmo && !r_owner) ? 8'hff : i_dat;
    o_m1_dat   = (tmo && r_owner) ? 8'hff : i_dat;

    o_grant    = r_grant;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_m0_cs || i_m1_cs) begin
            r_state <= BUSY;
            r_owner <= next_owner;
            r_grant <= next_owner ? 2'b10 : 2'b01;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          if (done || tmo || abort) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= r_owner;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed test of bus_arbiter with TIMEOUT = 4.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time
// unit after that, well away from the next edge.
module tb_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_m0_cs, i_m0_we, i_m1_cs, i_m1_we;
  logic [15:0] i_m0_addr, i_m1_addr;
  logic [7:0]  i_m0_dat, i_m1_dat;
  logic [7:0]  o_m0_dat, o_m1_dat;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic        o_cs, o_we;
  logic [15:0] o_addr;
  logic [7:0]  o_dat;
  logic [7:0]  i_dat;
  logic        i_ack;
  logic [1:0]  o_grant;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 i_clk = ~i_clk;

  bus_arbiter #(.TIMEOUT(8'd4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_cs(i_m0_cs), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_cs(i_m1_cs), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_cs(o_cs), .o_we(o_we), .o_addr(o_addr), .o_dat(o_dat),
    .i_dat(i_dat), .i_ack(i_ack), .o_grant(o_grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1;
    i_m0_cs = 0; i_m0_we = 0; i_m0_addr = '0; i_m0_dat = '0;
    i_m1_cs = 0; i_m1_we = 0; i_m1_addr = '0; i_m1_dat = '0;
    i_dat = '0; i_ack = 0;
    step(); step();
    #1;
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_cs", 32'(o_cs), 32'h0);
    chk("rst_we", 32'(o_we), 32'h0);
    i_reset = 1'b0;

    // Single write by m0, slave acks on the 3rd BUSY cycle
    i_m0_cs = 1; i_m0_we = 1; i_m0_addr = 16'h1a00; i_m0_dat = 8'h4d;
    #1;
    chk("wr_cs_t", 32'(o_cs), 32'h0);
    chk("wr_grant_t", 32'(o_grant), 32'h0);
    step(); #1;
    chk("wr_cs_t1", 32'(o_cs), 32'h1);
    chk("wr_grant_b1", 32'(o_grant), 32'h1);
    chk("wr_addr", 32'(o_addr), 32'h1a00);
    chk("wr_dat", 32'(o_dat), 32'h4d);
    chk("wr_we", 32'(o_we), 32'h1);
    chk("wr_noack_b1", 32'(o_m0_ack), 32'h0);
    step(); #1;
    chk("wr_noack_b2", 32'(o_m0_ack), 32'h0);
    step();
    i_ack = 1; #1;
    chk("wr_ack", 32'(o_m0_ack), 32'h1);
    chk("wr_err", 32'(o_m0_err), 32'h0);
    chk("wr_m1_ack", 32'(o_m1_ack), 32'h0);
    step();
    i_m0_cs = 0; i_m0_we = 0; i_ack = 0; #1;
    chk("wr_grant_idle", 32'(o_grant), 32'h0);
    chk("wr_cs_idle", 32'(o_cs), 32'h0);
    chk("wr_addr_idle", 32'(o_addr), 32'h0);

    // Tie after reset: m0 first, then m1 at the IDLE cycle after m0's ack
    i_reset = 1; step(); i_reset = 0;
    i_m0_cs = 1; i_m1_cs = 1; i_m0_addr = 16'h0010; i_m1_addr = 16'h0020;
    step(); #1;
    chk("tie_grant0", 32'(o_grant), 32'h1);
    chk("tie_addr0", 32'(o_addr), 32'h0010);
    i_ack = 1; i_dat = 8'h11; #1;
    chk("tie_ack0", 32'(o_m0_ack), 32'h1);
    chk("tie_dat0", 32'(o_m0_dat), 32'h11);
    step();
    i_m0_cs = 0; i_ack = 0; #1;
    chk("tie_idle_grant", 32'(o_grant), 32'h0);
    chk("tie_idle_cs", 32'(o_cs), 32'h0);
    step(); #1;
    chk("tie_grant1", 32'(o_grant), 32'h2);
    chk("tie_addr1", 32'(o_addr), 32'h0020);
    i_dat = 8'h5a; i_ack = 1; #1;
    chk("tie_ack1", 32'(o_m1_ack), 32'h1);
    chk("tie_dat1", 32'(o_m1_dat), 32'h5a);
    chk("tie_m0_noack", 32'(o_m0_ack), 32'h0);
    step();
    i_m1_cs = 0; i_ack = 0; #1;
    chk("tie_end_grant", 32'(o_grant), 32'h0);

    // Round robin, both requesting continuously
    i_m0_cs = 1; i_m1_cs = 1;
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      chk("rr_grant", 32'(o_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      i_ack = 1; #1;
      chk("rr_ack", 32'({o_m1_ack, o_m0_ack}), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      i_ack = 0; #1;
      chk("rr_idle", 32'(o_grant), 32'h0);
    end
    i_m0_cs = 0; i_m1_cs = 0;
    step();

    // Timeout on m1 after 4 BUSY cycles without ack
    i_m1_cs = 1; i_dat = 8'h33;
    step(); #1;
    chk("to_grant", 32'(o_grant), 32'h2);
    step(); step(); #1;
    chk("to_b3_ack", 32'(o_m1_ack), 32'h0);
    step(); #1;
    chk("to_ack", 32'(o_m1_ack), 32'h1);
    chk("to_err", 32'(o_m1_err), 32'h1);
    chk("to_dat", 32'(o_m1_dat), 32'hff);
    chk("to_m0_ack", 32'(o_m0_ack), 32'h0);
    step();
    i_m1_cs = 0; #1;
    chk("to_idle", 32'(o_grant), 32'h0);

    // Timeout variant: ack on the same cycle wins
    i_m1_cs = 1;
    step(); step(); step(); step();
    i_ack = 1; i_dat = 8'hc3; #1;
    chk("tov_ack", 32'(o_m1_ack), 32'h1);
    chk("tov_err", 32'(o_m1_err), 32'h0);
    chk("tov_dat", 32'(o_m1_dat), 32'hc3);
    step();
    i_m1_cs = 0; i_ack = 0; #1;
    chk("tov_idle", 32'(o_grant), 32'h0);

    // Reset while m0 owns the bus
    i_m0_cs = 1;
    step(); #1;
    chk("rb_grant", 32'(o_grant), 32'h1);
    i_reset = 1; #1;
    chk("rb_cs_in_rst", 32'(o_cs), 32'h0);
    chk("rb_noack_in_rst", 32'(o_m0_ack), 32'h0);
    step();
    i_reset = 0; i_m0_cs = 0; i_ack = 1; #1;
    chk("rb_grant_after", 32'(o_grant), 32'h0);
    chk("rb_cs_after", 32'(o_cs), 32'h0);
    chk("rb_spur_ack", 32'({o_m1_ack, o_m0_ack}), 32'h0);
    step();
    i_ack = 0; #1;
    chk("rb_still_idle", 32'(o_grant), 32'h0);

    // Abort: m1 drops cs in its 2nd BUSY cycle, m0 pending
    i_m1_cs = 1;
    step(); #1;
    chk("ab_grant", 32'(o_grant), 32'h2);
    i_m0_cs = 1;
    step();
    i_m1_cs = 0; #1;
    chk("ab_cs", 32'(o_cs), 32'h0);
    chk("ab_noack", 32'({o_m1_err, o_m1_ack, o_m0_err, o_m0_ack}), 32'h0);
    step(); #1;
    chk("ab_idle", 32'(o_grant), 32'h0);
    chk("ab_idle_cs", 32'(o_cs), 32'h0);
    step(); #1;
    chk("ab_m0_grant", 32'(o_grant), 32'h1);
    chk("ab_m0_cs", 32'(o_cs), 32'h1);
    i_ack = 1; #1;
    chk("ab_m0_ack", 32'(o_m0_ack), 32'h1);
    step();
    i_m0_cs = 0; i_ack = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
